// File: rtl/rtype_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rtype_sequencer_if
// Description : Instruction offer/accept handshake between a fetch source and
//               the R-type sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rtype_sequencer_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;

    modport master (output instr_valid, output instr, input  instr_ready);
    modport slave  (input  instr_valid, input  instr, output instr_ready);
endinterface
`default_nettype wire

// File: rtl/rtype_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rtype_sequencer
// Description : Four-state sequencer that decodes RISC-V R-type add/sub/and/or,
//               drives an external ALU and writes back to a 32x64 register file.
// Revision    : 1.0 - initial release
// ============================================================================
module rtype_sequencer #(
    parameter int CNT_W = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    rtype_sequencer_if.slave        ibus,
    input  wire logic               ld_en,
    input  wire logic [4:0]         ld_addr,
    input  wire logic [63:0]        ld_data,
    input  wire logic [4:0]         dbg_addr,
    output logic [63:0]             dbg_data,
    output logic [63:0]             alu_a,
    output logic [63:0]             alu_b,
    output logic [3:0]              alu_cs,
    output logic [1:0]              alu_op,
    input  wire logic [63:0]        alu_result,
    input  wire logic               alu_zero,
    input  wire logic               alu_overflow,
    output logic                    done,
    output logic [4:0]              wb_rd,
    output logic [63:0]             wb_data,
    output logic                    illegal,
    output logic                    z_flag,
    output logic                    v_flag,
    output logic [CNT_W-1:0]        retired
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DECODE = 2'd1;
    localparam logic [1:0] c_EXEC   = 2'd2;
    localparam logic [1:0] c_WB     = 2'd3;

    localparam logic [6:0] c_OPCODE_OP = 7'b0110011;

    logic [1:0]       r_state;
    logic [31:0]      r_instr;
    logic [63:0]      r_regs [32];
    logic [63:0]      r_alu_a;
    logic [63:0]      r_alu_b;
    logic [3:0]       r_alu_cs;
    logic [1:0]       r_alu_op;
    logic [4:0]       r_wb_rd;
    logic [63:0]      r_res;
    logic             r_zero;
    logic             r_ovf;
    logic             r_z;
    logic             r_v;
    logic [CNT_W-1:0] r_retired;

    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [9:0]       w_funct;
    logic             w_legal;
    logic [63:0]      w_rs1_val;
    logic [63:0]      w_rs2_val;

    assign w_rs1   = r_instr[19:15];
    assign w_rs2   = r_instr[24:20];
    assign w_funct = {r_instr[31:25], r_instr[14:12]};

    always_comb begin
        w_legal = 1'b0;
        if (r_instr[6:0] == c_OPCODE_OP) begin
            case (w_funct)
                10'b0000000_000,
                10'b0100000_000,
                10'b0000000_111,
                10'b0000000_110: w_legal = 1'b1;
                default:         w_legal = 1'b0;
            endcase
        end
    end

    // x0 is forced to zero on every read path regardless of array contents
    assign w_rs1_val = (w_rs1 == 5'd0)    ? 64'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0)    ? 64'd0 : r_regs[w_rs2];
    assign dbg_data  = (dbg_addr == 5'd0) ? 64'd0 : r_regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_instr   <= '0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_cs  <= '0;
            r_alu_op  <= '0;
            r_wb_rd   <= '0;
            r_res     <= '0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_z       <= 1'b0;
            r_v       <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    // A preload and an accept in the same cycle both take effect
                    if (ld_en && (ld_addr != 5'd0)) begin
                        r_regs[ld_addr] <= ld_data;
                    end
                    if (ibus.instr_valid) begin
                        r_instr <= ibus.instr;
                        r_state <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    if (w_legal) begin
                        r_alu_a  <= w_rs1_val;
                        r_alu_b  <= w_rs2_val;
                        r_alu_cs <= {r_instr[30], r_instr[14:12]};
                        r_alu_op <= 2'b10;
                        r_wb_rd  <= r_instr[11:7];
                        r_state  <= c_EXEC;
                    end else begin
                        r_state  <= c_IDLE;
                    end
                end
                c_EXEC: begin
                    r_res   <= alu_result;
                    r_zero  <= alu_zero;
                    r_ovf   <= alu_overflow;
                    r_state <= c_WB;
                end
                c_WB: begin
                    if (r_wb_rd != 5'd0) begin
                        r_regs[r_wb_rd] <= r_res;
                    end
                    r_z       <= r_zero;
                    r_v       <= r_ovf;
                    r_retired <= r_retired + CNT_W'(1);
                    r_state   <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign ibus.instr_ready = (r_state == c_IDLE);
    assign illegal          = (r_state == c_DECODE) && !w_legal;
    assign done             = (r_state == c_WB);
    assign alu_a            = r_alu_a;
    assign alu_b            = r_alu_b;
    assign alu_cs           = r_alu_cs;
    assign alu_op           = r_alu_op;
    assign wb_rd            = r_wb_rd;
    assign wb_data          = r_res;
    assign z_flag           = r_z;
    assign v_flag           = r_v;
    assign retired          = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_rtype_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtype_sequencer
// Description : Directed self-checking bench for rtype_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtype_sequencer;

    logic        clk;
    logic        rst_n;
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [63:0] ld_data;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_cs;
    logic [1:0]  alu_op;
    logic        alu_zero, alu_overflow;
    logic        done, illegal, z_flag, v_flag;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [15:0] retired;

    logic [63:0] w2_dbg_data, w2_alu_a, w2_alu_b, w2_wb_data;
    logic [3:0]  w2_alu_cs;
    logic [1:0]  w2_alu_op;
    logic        w2_done, w2_illegal, w2_z, w2_v;
    logic [4:0]  w2_wb_rd;
    logic [3:0]  retired_w;

    int n_tests = 0;
    int n_fail  = 0;

    rtype_sequencer_if u_if ();
    rtype_sequencer_if u_if_w ();

    assign u_if_w.instr_valid = u_if.instr_valid;
    assign u_if_w.instr       = u_if.instr;

    rtype_sequencer #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .ibus(u_if.slave),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cs(alu_cs), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .done(done), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal),
        .z_flag(z_flag), .v_flag(v_flag), .retired(retired)
    );

    // Narrow-counter twin so counter wrap is reachable in a short run
    rtype_sequencer #(.CNT_W(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .ibus(u_if_w.slave),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(w2_dbg_data),
        .alu_a(w2_alu_a), .alu_b(w2_alu_b), .alu_cs(w2_alu_cs), .alu_op(w2_alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .done(w2_done), .wb_rd(w2_wb_rd), .wb_data(w2_wb_data), .illegal(w2_illegal),
        .z_flag(w2_z), .v_flag(w2_v), .retired(retired_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU answering the sequencer's control code
    always_comb begin
        alu_result   = 64'd0;
        alu_overflow = 1'b0;
        case (alu_cs)
            4'b0000: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[63] == alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            4'b1000: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[63] != alu_b[63]) && (alu_result[63] != alu_a[63]);
            end
            4'b0111: alu_result = alu_a & alu_b;
            4'b0110: alu_result = alu_a | alu_b;
            default: alu_result = 64'd0;
        endcase
        alu_zero = (alu_result == 64'd0);
    end

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] addr, input logic [63:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic load(input logic [4:0] addr, input logic [63:0] data);
        ld_en = 1'b1; ld_addr = addr; ld_data = data;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic issue_legal(input string tag, input logic [31:0] w, input logic [3:0] cs,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input logic [63:0] res,
                               input logic busy_ld);
        u_if.instr = w; u_if.instr_valid = 1'b1;
        tick();
        u_if.instr_valid = 1'b0;
        ld_en = busy_ld; ld_addr = 5'd11; ld_data = 64'd99;
        check({tag, "_ready_dec"}, u_if.instr_ready, 1'b0);
        check({tag, "_illegal_dec"}, illegal, 1'b0);
        tick();
        check({tag, "_alu_a"}, alu_a, a);
        check({tag, "_alu_b"}, alu_b, b);
        check({tag, "_alu_cs"}, alu_cs, cs);
        check({tag, "_alu_op"}, alu_op, 2'b10);
        check({tag, "_done_exec"}, done, 1'b0);
        tick();
        check({tag, "_done_wb"}, done, 1'b1);
        check({tag, "_wb_rd"}, wb_rd, rd);
        check({tag, "_wb_data"}, wb_data, res);
        tick();
        ld_en = 1'b0;
        check({tag, "_done_idle"}, done, 1'b0);
        check({tag, "_ready_idle"}, u_if.instr_ready, 1'b1);
    endtask

    task automatic issue_illegal(input string tag, input logic [31:0] w);
        u_if.instr = w; u_if.instr_valid = 1'b1;
        tick();
        u_if.instr_valid = 1'b0;
        check({tag, "_illegal"}, illegal, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        tick();
        check({tag, "_illegal_idle"}, illegal, 1'b0);
        check({tag, "_ready"}, u_if.instr_ready, 1'b1);
        check({tag, "_done_idle"}, done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        u_if.instr_valid = 1'b0; u_if.instr = '0;
        tick(); tick();
        check("rst_retired", retired, 16'd0);
        check("rst_done", done, 1'b0);
        check("rst_alu_op", alu_op, 2'b00);
        rst_n = 1'b1;
        tick();
        check("rst_ready", u_if.instr_ready, 1'b1);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_flags", {z_flag, v_flag, illegal}, 3'b000);

        load(5'd1, 64'd5);
        load(5'd2, 64'd3);
        check_reg("ld_x1", 5'd1, 64'd5);

        issue_legal("add_x3", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 4'b0000, 64'd5, 64'd3, 5'd3, 64'd8, 1'b0);
        check("add_retired", retired, 16'd1);
        check_reg("add_x3_val", 5'd3, 64'd8);

        issue_legal("sub_x4", rtype(7'h20, 5'd1, 5'd2, 3'b000, 5'd4), 4'b1000, 64'd3, 64'd5, 5'd4,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check("sub_x4_z", z_flag, 1'b0);
        check("sub_x4_v", v_flag, 1'b0);
        issue_legal("sub_x5", rtype(7'h20, 5'd1, 5'd1, 3'b000, 5'd5), 4'b1000, 64'd5, 64'd5, 5'd5, 64'd0, 1'b0);
        check("sub_x5_z", z_flag, 1'b1);
        check("sub_retired", retired, 16'd3);

        issue_illegal("ill_opc", {7'h00, 5'd2, 5'd1, 3'b000, 5'd6, 7'b0010011});
        issue_illegal("ill_f7", rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd6));
        check("ill_retired", retired, 16'd3);
        check("ill_z_kept", z_flag, 1'b1);
        check_reg("ill_x6", 5'd6, 64'd0);

        issue_legal("add_x0", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 4'b0000, 64'd5, 64'd3, 5'd0, 64'd8, 1'b0);
        check_reg("x0_zero", 5'd0, 64'd0);
        check("x0_retired", retired, 16'd4);

        issue_legal("and_x7", rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd7), 4'b0111, 64'd5, 64'd3, 5'd7, 64'd1, 1'b0);
        issue_legal("or_x8", rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd8), 4'b0110, 64'd5, 64'd3, 5'd8, 64'd7, 1'b0);

        // Preload on the accept edge, and stray preloads while busy
        ld_en = 1'b1; ld_addr = 5'd9; ld_data = 64'd10;
        issue_legal("ldacc_x10", rtype(7'h00, 5'd9, 5'd9, 3'b000, 5'd10), 4'b0000, 64'd10, 64'd10, 5'd10, 64'd20, 1'b1);
        check_reg("busy_ld_x11", 5'd11, 64'd0);
        check_reg("ldacc_x9", 5'd9, 64'd10);
        issue_legal("raw_x10", rtype(7'h00, 5'd10, 5'd10, 3'b000, 5'd10), 4'b0000, 64'd20, 64'd20, 5'd10, 64'd40, 1'b0);

        load(5'd15, 64'h7FFF_FFFF_FFFF_FFFF);
        issue_legal("ovf_x16", rtype(7'h00, 5'd1, 5'd15, 3'b000, 5'd16), 4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd5,
                    5'd16, 64'h8000_0000_0000_0004, 1'b0);
        check("ovf_v", v_flag, 1'b1);
        check("ovf_retired", retired, 16'd9);

        // Reset while EXEC is in flight
        u_if.instr = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd12); u_if.instr_valid = 1'b1;
        tick();
        u_if.instr_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_retired", retired, 16'd0);
        check("mid_rst_alu_a", alu_a, 64'd0);
        check("mid_rst_v", v_flag, 1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", u_if.instr_ready, 1'b1);
        check("post_rst_done", done, 1'b0);
        tick();
        check("post_rst_done2", done, 1'b0);
        check_reg("post_rst_x12", 5'd12, 64'd0);
        check_reg("post_rst_x1", 5'd1, 64'd0);

        // Back-to-back accepts with instr_valid held high
        load(5'd1, 64'd5);
        u_if.instr = rtype(7'h00, 5'd1, 5'd13, 3'b000, 5'd13);
        u_if.instr_valid = 1'b1;
        for (int e = 0; e <= 64; e++) begin
            check("b2b_ready", u_if.instr_ready, (e % 4) == 0);
            if (e == 60) check("wrap_pre", retired_w, 4'hF);
            if (e == 64) begin
                check("wrap_zero", retired_w, 4'h0);
                check("b2b_retired", retired, 16'd16);
                u_if.instr_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check_reg("b2b_x13", 5'd13, 64'd80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
